imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
// Boot-time program loader placed directly upstream of the DATAPATH instruction memory.
// Receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
// Writes each word into instruction memory through a write port and holds the CPU while loading.
// Replaces the simulation-only memory preload, so the same image can be loaded in hardware.
// PARAMETERS
// ADDR_W   8    instruction-memory word-address width; DEPTH = 2**ADDR_W words
// HDR_LEN  2    header bytes carrying the 16-bit word count N, sent MSB first
// PORTS
// clk           in   1       system clock; all state changes on rising edge
// rst           in   1       asynchronous reset, active-high
// start         in   1       one-cycle pulse that begins a load; ignored while busy=1
// in_valid      in   1       in_data is valid this cycle
// in_ready      out  1       loader accepts a byte; a transfer occurs when in_valid & in_ready
// in_data       in   8       stream byte
// imem_we       out  1       instruction-memory write strobe, high for exactly 1 cycle per word
// imem_addr     out  ADDR_W  word address for the write
// imem_wdata    out  32      word to write
// cpu_hold      out  1       stalls the DATAPATH PC and register writes while high
// busy          out  1       load in progress
// done          out  1       sticky: last load completed; cleared by the next accepted start
// error         out  1       sticky: header N > DEPTH; cleared by the next accepted start
// words_loaded  out  ADDR_W+1 count of words written in the current or last load
// BEHAVIOUR
// - Reset (async, any time, including mid-load): state=IDLE; in_ready, imem_we, cpu_hold, busy,
//   done and error are 0; imem_addr, imem_wdata and words_loaded are 0. Partially written memory is not undone.
// - FSM states are IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE and ERR.
//   IDLE: on start go to HDR_HI; clear done, error and words_loaded; set busy and cpu_hold.
//   HDR_HI / HDR_LO: in_ready=1; each accepted byte loads count[15:8] or count[7:0].
//     After HDR_LO: if N==0 go to DONE; if N>DEPTH go to ERR; else go to DATA.
//   DATA: in_ready=1; byte index b=0..3 shifts the byte into the word, MSB first.
//     The 4th accepted byte goes to WRITE.
//   WRITE: in_ready=0; imem_we=1 for one cycle; imem_addr=words_loaded[ADDR_W-1:0].
//     Then words_loaded increments. If words_loaded==N go to DONE, else go to DATA.
//   DONE: done=1, busy=0, cpu_hold=0; go to IDLE on the next cycle (done stays sticky).
//   ERR: error=1, busy=0, cpu_hold=0, no memory write; go to IDLE.
// - Latency: imem_we rises exactly 1 cycle after the cycle in which the 4th byte is accepted.
//   Minimum 5 cycles per word.
// - Backpressure: in_valid gaps of any length are tolerated; no byte is dropped or duplicated.
//   in_ready is a registered state decode and does not depend on in_valid combinationally.
// - start in the same cycle as a byte transfer while busy: start ignored, byte processed.
// - Address wrap cannot occur: N<=DEPTH is enforced, so the last address is DEPTH-1.
// - words_loaded saturates at N and holds its value after DONE until the next start.
// - Bytes offered in IDLE, DONE or ERR are not accepted (in_ready=0).
// STRUCTURE
// - Shared package holds: the state enum, IMEM_WORD_W=32, BYTE_W=8, HDR_LEN.
// - One natural sub-module: byte_to_word_packer, a 4-byte shift register with a byte counter
//   and a word_valid pulse. The FSM, counters and the memory write port stay in imem_loader.
// - Top-level DATAPATH integration: OR cpu_hold into the PC enable and the register-file
//   write enable; mux imem write port versus fetch read.
// TESTING
// 1. N=2, bytes 00 02 DE AD BE EF 01 23 45 67, valid every cycle ->
//    writes 0xDEADBEEF@0, then 0x01234567@1; done=1; words_loaded=2; cpu_hold falls after WRITE.
// 2. N=0 (bytes 00 00) -> no imem_we; done=1; error=0; busy high for exactly 3 cycles.
// 3. ADDR_W=8, header 01 01 (N=257) -> error=1; no imem_we;
//    in_ready=0 after the header; the next start clears error.
// 4. N=1, random in_valid gaps of 0-7 cycles -> single write of the exact word; no extra in_ready handshakes.
// 5. start pulsed mid-load at byte 3 -> ignored; load completes with correct addresses and data.
// 6. rst asserted in the middle of word 2 of N=3 -> all outputs 0 asynchronously;
//    a new start with N=1 writes address 0 correctly.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// Holds the FSM state encoding and the stream/word geometry.
package imem_loader_pkg;

    localparam int IMEM_WORD_W = 32;
    localparam int BYTE_W      = 8;
    localparam int HDR_LEN     = 2;
    localparam int WORD_BYTES  = IMEM_WORD_W / BYTE_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR_HI = 3'd1,
        S_HDR_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    // States in which the loader takes bytes from the stream.
    function automatic logic is_rx_state(input state_t s);
        return (s == S_HDR_HI) || (s == S_HDR_LO) || (s == S_DATA);
    endfunction

endpackage

// File: rtl/imem_loader_byte_to_word_packer.sv
// Collects WORD_BYTES stream bytes MSB first into one instruction word.
// word_valid marks the cycle in which the last byte of a word is taken.
module byte_to_word_packer
    import imem_loader_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   byte_valid,
    input  logic [BYTE_W-1:0]      byte_data,
    output logic [IMEM_WORD_W-1:0] word,
    output logic                   word_valid
);

    localparam int IDX_W = $clog2(WORD_BYTES);

    logic [WORD_BYTES-1:0][BYTE_W-1:0] sr;
    logic [IDX_W-1:0]                  idx;

    assign word       = sr;
    assign word_valid = byte_valid && (idx == IDX_W'(WORD_BYTES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr  <= '0;
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (byte_valid) begin
            sr  <= {sr[WORD_BYTES-2:0], byte_data};
            // wraps back to 0 after the last byte of each word
            idx <= idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a 16-bit word-count header, then writes big-endian words
// into instruction memory while holding the CPU.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BYTE_W-1:0]      in_data,
    output logic                   imem_we,
    output logic [ADDR_W-1:0]      imem_addr,
    output logic [IMEM_WORD_W-1:0] imem_wdata,
    output logic                   cpu_hold,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [ADDR_W:0]        words_loaded
);

    localparam int          CNT_W   = HDR_LEN * BYTE_W;
    localparam logic [16:0] DEPTH17 = 17'(2 ** ADDR_W);

    state_t             state, nxt;
    logic [CNT_W-1:0]   count;
    logic [ADDR_W:0]    wl_inc;
    logic [16:0]        hdr_n;
    logic               fire;
    logic               start_ok;
    logic               pk_valid;
    logic               pk_word_valid;
    logic [IMEM_WORD_W-1:0] pk_word;

    assign fire     = in_valid && in_ready;
    assign start_ok = (state == S_IDLE) && start;
    assign pk_valid = fire && (state == S_DATA);
    assign wl_inc   = words_loaded + (ADDR_W + 1)'(1);
    // Word count as it will be once the low header byte lands this cycle.
    assign hdr_n    = {1'b0, count[CNT_W-1:BYTE_W], in_data};

    byte_to_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_ok),
        .byte_valid (pk_valid),
        .byte_data  (in_data),
        .word       (pk_word),
        .word_valid (pk_word_valid)
    );

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:   if (start) nxt = S_HDR_HI;
            S_HDR_HI: if (fire)  nxt = S_HDR_LO;
            S_HDR_LO: begin
                if (fire) begin
                    if (hdr_n == 17'd0)        nxt = S_DONE;
                    else if (hdr_n > DEPTH17)  nxt = S_ERR;
                    else                       nxt = S_DATA;
                end
            end
            S_DATA:   if (pk_word_valid) nxt = S_WRITE;
            S_WRITE:  nxt = (17'(wl_inc) == {1'b0, count}) ? S_DONE : S_DATA;
            S_DONE:   nxt = S_IDLE;
            S_ERR:    nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            in_ready     <= 1'b0;
            busy         <= 1'b0;
            cpu_hold     <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            count        <= '0;
            words_loaded <= '0;
        end else begin
            state    <= nxt;
            // registered decode so in_ready never depends on in_valid
            in_ready <= is_rx_state(nxt);
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                        busy         <= 1'b1;
                        cpu_hold     <= 1'b1;
                    end
                end
                S_HDR_HI: if (fire) count[CNT_W-1:BYTE_W] <= in_data;
                S_HDR_LO: if (fire) count[BYTE_W-1:0]     <= in_data;
                S_WRITE:  words_loaded <= wl_inc;
                S_DONE: begin
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    cpu_hold <= 1'b0;
                end
                S_ERR: begin
                    error    <= 1'b1;
                    busy     <= 1'b0;
                    cpu_hold <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // N never exceeds DEPTH, so the address field cannot wrap.
    assign imem_we    = (state == S_WRITE);
    assign imem_addr  = words_loaded[ADDR_W-1:0];
    assign imem_wdata = pk_word;

endmodule
